// File: rtl/mc_defs.sv
// Shared encodings for the multicycle controller: state codes, opcode and
// funct values, and the select codes driven onto the datapath.
package mc_defs;

  // Instruction-phase state encodings
  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // R-type funct codes
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  // Next-PC source codes
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // Destination register codes
  localparam logic [1:0] RD_R31 = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_RD  = 2'b10;

  // Branch flavour, used to pick the flag that decides the branch
  localparam logic [1:0] BR_BEQ  = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b01;
  localparam logic [1:0] BR_BLTZ = 2'b10;

  // One-hot instruction class produced by the decoder
  typedef struct packed {
    logic rtype;
    logic imm;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic jal;
    logic jr;
    logic halt;
    logic illegal;
  } ins_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps OpCode/func to a one-hot class
// plus the ALU operation, extension mode and shift-amount select.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0]  OpCode,
  input  logic [5:0]  func,
  output ins_class_t  cls,
  output logic [2:0]  alu_op,
  output logic        ext_sel,
  output logic        use_shamt,
  output logic [1:0]  br_type
);

  // Decode; func only matters under the R-type opcode
  always_comb begin
    cls       = '0;
    alu_op    = ALU_ADD;
    ext_sel   = 1'b1;
    use_shamt = 1'b0;
    br_type   = BR_BEQ;
    case (OpCode)
      OP_RTYPE: begin
        case (func)
          F_ADD: cls.rtype = 1'b1;
          F_SUB: begin cls.rtype = 1'b1; alu_op = ALU_SUB; end
          F_AND: begin cls.rtype = 1'b1; alu_op = ALU_AND; end
          F_OR:  begin cls.rtype = 1'b1; alu_op = ALU_OR;  end
          F_SLT: begin cls.rtype = 1'b1; alu_op = ALU_SLT; end
          F_SLL: begin cls.rtype = 1'b1; alu_op = ALU_SLL; use_shamt = 1'b1; end
          F_JR:  cls.jr = 1'b1;
          default: cls.illegal = 1'b1;
        endcase
      end
      OP_ADDIU: cls.imm = 1'b1;
      OP_ANDI:  begin cls.imm = 1'b1; alu_op = ALU_AND; ext_sel = 1'b0; end
      OP_ORI:   begin cls.imm = 1'b1; alu_op = ALU_OR;  ext_sel = 1'b0; end
      OP_XORI:  begin cls.imm = 1'b1; alu_op = ALU_XOR; ext_sel = 1'b0; end
      OP_SLTI:  begin cls.imm = 1'b1; alu_op = ALU_SLT; end
      OP_LW:    cls.load  = 1'b1;
      OP_SW:    cls.store = 1'b1;
      OP_BEQ:   begin cls.branch = 1'b1; alu_op = ALU_SUB; br_type = BR_BEQ; end
      OP_BNE:   begin cls.branch = 1'b1; alu_op = ALU_SUB; br_type = BR_BNE; end
      // bltz adds rs to $0 so the sign flag reflects rs itself
      OP_BLTZ:  begin cls.branch = 1'b1; alu_op = ALU_ADD; br_type = BR_BLTZ; end
      OP_J:     cls.jump = 1'b1;
      OP_JAL:   cls.jal  = 1'b1;
      OP_HALT:  cls.halt = 1'b1;
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: instruction-phase state machine and
// per-state datapath enables/selects, combinational from the state register.
module multicycle_ctrl
  import mc_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp
);

  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  ins_class_t  cls;
  logic [2:0]  alu_op;
  logic        ext_sel;
  logic        use_shamt;
  logic [1:0]  br_type;
  logic        br_taken;

  mc_decode u_decode (
    .OpCode    (OpCode),
    .func      (func),
    .cls       (cls),
    .alu_op    (alu_op),
    .ext_sel   (ext_sel),
    .use_shamt (use_shamt),
    .br_type   (br_type)
  );

  assign state = state_reg;

  // Branch condition from the ALU flags
  always_comb begin
    case (br_type)
      BR_BEQ:  br_taken = zero;
      BR_BNE:  br_taken = ~zero;
      BR_BLTZ: br_taken = sign;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state selection; unused encodings recover to IF
  always_comb begin
    state_next = S_IF;
    case (state_reg)
      S_IF:  state_next = S_ID;
      S_ID: begin
        if (cls.halt)
          state_next = S_HALT;
        else if (cls.jump || cls.jal || cls.jr || cls.illegal)
          state_next = S_IF;
        else
          state_next = S_EXE;
      end
      S_EXE: begin
        if (cls.branch)
          state_next = S_IF;
        else if (cls.load || cls.store)
          state_next = S_MEM;
        else
          state_next = S_WB;
      end
      S_MEM:  state_next = cls.load ? S_WB : S_IF;
      S_WB:   state_next = S_IF;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  // State register with synchronous reset to IF
  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= S_IF;
    else
      state_reg <= state_next;
  end

  // Per-state enables and selects; everything held low while reset is high
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    RegDst    = RD_R31;
    PCSrc     = PC_PLUS4;
    ALUOp     = ALU_ADD;
    if (!reset) begin
      // ALU controls stay stable for the whole execution of the instruction
      if (state_reg == S_ID || state_reg == S_EXE ||
          state_reg == S_MEM || state_reg == S_WB) begin
        ALUOp   = alu_op;
        ALUSrcA = use_shamt;
        ALUSrcB = cls.imm | cls.load | cls.store;
        ExtSel  = ext_sel;
      end
      case (state_reg)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
        end
        S_ID: begin
          if (cls.jump) begin
            PCWre = 1'b1;
            PCSrc = PC_JUMP;
          end else if (cls.jal) begin
            PCWre     = 1'b1;
            PCSrc     = PC_JUMP;
            RegWre    = 1'b1;
            RegDst    = RD_R31;
            WrRegDSrc = 1'b0;
          end else if (cls.jr) begin
            PCWre = 1'b1;
            PCSrc = PC_RS;
          end else if (cls.illegal) begin
            PCWre = 1'b1;
            PCSrc = PC_PLUS4;
          end
        end
        S_EXE: begin
          if (cls.branch) begin
            PCWre = 1'b1;
            PCSrc = br_taken ? PC_BRANCH : PC_PLUS4;
          end
        end
        S_MEM: begin
          mRD = cls.load;
          if (cls.store) begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end
        end
        S_WB: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          RegDst    = cls.rtype ? RD_RD : RD_RT;
          DBDataSrc = cls.load;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control unit for the multicycle MIPS-subset CPU. It holds the instruction-phase state machine (IF/ID/EXE/MEM/WB/HALT) and drives every datapath enable and mux select. It consumes OpCode/func from the instruction register directly downstream of fetch and the zero/sign flags from the ALU. It produces IRWre, which gates the instruction register's capture.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces state IF
- OpCode  in  6  from instruction register
- func  in  6  from instruction register; valid only for R-type
- zero  in  1  ALU result == 0
- sign  in  1  ALU result bit 31
- state  out  3  current state (debug/trace)
- PCWre  out  1  PC load enable
- IRWre  out  1  instruction register load enable
- InsMemRW  out  1  instruction memory read
- RegWre  out  1  register file write enable
- ALUSrcA  out  1  1 = shamt (sa) to ALU A
- ALUSrcB  out  1  1 = extended immediate to ALU B
- ExtSel  out  1  1 = sign-extend immediate, 0 = zero-extend
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- DBDataSrc  out  1  1 = write-back from data memory
- WrRegDSrc  out  1  0 = PC+4 (jal) to register file, 1 = ALU/memory
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target
- ALUOp  out  3  000 ADD, 001 SUB, 010 SLL, 011 OR, 100 AND, 101 SLT, 110 XOR

## Operation
- Supported instructions:
  - R-type (OpCode 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - I-type: addiu 001001, andi 001100, ori 001101, xori 001110, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101, bltz 000001.
  - J-type: j 000010, jal 000011, halt 111111.
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
- Transitions:
  - IF→ID always.
  - ID→IF for j, jal, jr and unknown opcodes/functs; ID→HALT for halt; otherwise ID→EXE.
  - EXE→IF for beq/bne/bltz; EXE→MEM for lw/sw; otherwise EXE→WB.
  - MEM→WB for lw; MEM→IF for sw.
  - WB→IF.
  - HALT→HALT until reset.
- IF: InsMemRW=1, IRWre=1.
- PCWre=1 only in the terminal state of each instruction:
  - ID for j/jal/jr/unknown, EXE for branches, MEM for sw, WB for all others.
  - The PC therefore loads on the edge that returns to IF.
- PCSrc in the terminal state:
  - j/jal: 11; jr: 10.
  - beq: 01 if zero; bne: 01 if !zero; bltz: 01 if sign; otherwise 00.
- jal: RegWre=1, RegDst=00, WrRegDSrc=0 in ID.
- WB: RegWre=1, WrRegDSrc=1; RegDst=10 for R-type, 01 for I-type; DBDataSrc=1 only for lw.
- MEM: mRD=1 for lw, mWR=1 for sw.
- ALUOp and sources are held from ID through WB:
  - ALUOp: sub/beq/bne → SUB; bltz → ADD with rt=$0.
  - ALUSrcB=1 for immediate, lw and sw.
  - ALUSrcA=1 for sll.
  - ExtSel=0 for andi/ori/xori, 1 otherwise.
- func is ignored when OpCode ≠ 000000.
- Unknown opcode behaves as a NOP: PC+4, no writes.

## Timing
- Outputs are combinational from the registered state plus OpCode/func/zero/sign. There is no output register.
- While reset=1: state is forced to IF on each edge and all enables (PCWre, IRWre, RegWre, mRD, mWR, InsMemRW) are driven 0. Selects are 0.
- The first edge with reset=0 executes IF.
- Reset mid-instruction aborts it; no enable fires in that cycle.
- Cycle counts: j/jal/jr 2; beq/bne/bltz 3; sw 4; R-type/imm 4; lw 5; halt 2, then stalls.
- IRWre is high only in IF, so OpCode is stable from ID onward.
- In HALT: PCWre=RegWre=mWR=IRWre=0 indefinitely.

## Structure
- Package mc_defs holds:
  - state encodings
  - opcode/funct constants
  - ALUOp, PCSrc and RegDst codes
- Sub-module mc_decode: combinational OpCode/func → one-hot instruction class (rtype, imm, load, store, branch, jump, jal, jr, halt, illegal) plus ALUOp/ExtSel.
- The top contains the state register, next-state logic and per-state enable generation.

## Test plan
- add ($3=$1+$2, func 100000): IF,ID,EXE,WB. RegWre=1 only in WB with RegDst=10, ALUOp=000. PCWre=1 only in WB, PCSrc=00.
- lw: 5 states. mRD=1 in MEM; WB has DBDataSrc=1, RegDst=01. sw: mWR=1 in MEM, PCWre=1 in MEM, returns to IF after 4 cycles.
- beq with zero=1 → PCSrc=01, PCWre=1 in EXE. With zero=0 → PCSrc=00. bltz with sign=1 → PCSrc=01.
- jal: ID has RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1. Next state IF, 2 cycles total.
- halt (111111): state reaches 111 after 2 cycles. Hold for 20 cycles with all enables 0. Reset→IF next edge.
- Reset asserted during EXE of lw: mRD never asserts, state=IF after the edge. An unknown opcode 110011 gives PC+4 in ID with no RegWre/mWR.
